logicnet_input_packer: RTL and testbench
========================================

LOGICNET_INPUT_PACKER -- requirements
Module: logicnet_input_packer

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WORD_W, default 32, giving the input stream word width in bits.
REQ-002 The block SHALL have parameter NWORDS, default 16, giving the words per feature vector; vector width VEC_W = WORD_W*NWORDS, 512 by default.
REQ-003 The block SHALL have parameter LAT, default 4, giving the downstream classifier pipeline depth in cycles.
Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port s_data, input, WORD_W bits: stream word.
REQ-007 The block SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-008 The block SHALL have port s_last, input, 1 bit: the current word is the last word of its frame.
REQ-009 The block SHALL have port s_ready, output, 1 bit: the block accepts the word this cycle.
REQ-010 The block SHALL have port M0, output, VEC_W bits: registered feature vector for the classifier.
REQ-011 The block SHALL have port m0_valid, output, 1 bit: one-cycle pulse marking a new M0.
REQ-012 The block SHALL have port res_valid, output, 1 bit: classifier result matching an M0 is valid this cycle.
REQ-013 The block SHALL have ports err_short and err_long, outputs, 1 bit each: sticky frame-length error flags.

Function
REQ-014 A word SHALL be accepted on a cycle where s_valid and s_ready are both 1; no other cycle SHALL change frame state.
REQ-015 The FSM SHALL have two states, FILL and DRAIN; s_ready SHALL be 1 in both states and 0 only while rst is 1.
REQ-016 In FILL, accepted word k (counter value 0..NWORDS-1) SHALL be written to assembly buffer bits [WORD_W*k+WORD_W-1 : WORD_W*k].
REQ-017 An accepted word with k = NWORDS-1 and s_last = 1 SHALL cause, on the next edge: M0 := buffer with the final word merged; m0_valid = 1 for one cycle; counter and buffer cleared; state stays FILL.
REQ-018 An accepted word with s_last = 1 and k < NWORDS-1 (short frame) SHALL emit as in REQ-017 with all slots above k zero-filled, and SHALL set err_short.
REQ-019 An accepted word with k = NWORDS-1 and s_last = 0 (long frame) SHALL emit as in REQ-017, set err_long, and enter DRAIN.
REQ-020 In DRAIN, accepted words SHALL be discarded; an accepted word with s_last = 1 SHALL return the FSM to FILL with counter = 0.
REQ-021 M0 SHALL hold its value between emissions.
REQ-022 Back-to-back frames SHALL be accepted with no bubble, giving a maximum rate of one emission per NWORDS cycles.
REQ-023 A single-word frame (s_last = 1 at k = 0) SHALL emit that word in slot 0 with all other slots zero.
REQ-024 res_valid SHALL equal m0_valid delayed by exactly LAT cycles through a LAT-deep shift register; overlapping pulses SHALL be preserved individually.

Reset
REQ-025 While rst is 1: state = FILL; counter = 0; buffer, M0, m0_valid, res_valid shift register, err_short and err_long = 0; s_ready = 0.
REQ-026 Reset mid-frame SHALL discard the partial frame with no emission, and SHALL discard in-flight res_valid pulses.
REQ-027 err_short and err_long SHALL clear only on rst.

Configuration
REQ-028 When macro LOGICNET_PACKER_ERRCNT_EN is defined, the block SHALL add 8-bit outputs short_cnt and long_cnt that count short and long frames respectively, saturate at 255, and reset to 0.
REQ-029 When LOGICNET_PACKER_ERRCNT_EN is undefined, those ports and counters SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover: 16 consecutive words 0x00000000..0x0000000F, s_last on the 16th -> m0_valid pulses one cycle after the 16th acceptance, M0[31:0] = 0, M0[511:480] = 0xF, no error flag, res_valid pulses 4 cycles after m0_valid.
REQ-031 The bench SHALL cover: 3 words 0xA, 0xB, 0xC with s_last on the third -> M0[95:0] = {0xC, 0xB, 0xA}, M0[511:96] = 0, err_short = 1, short_cnt = 1 with the macro defined.
REQ-032 The bench SHALL cover: 20 words with s_last only on the 20th -> one emission after word 16, words 17-20 discarded, err_long = 1; next 16-word frame emits normally.
REQ-033 The bench SHALL cover: two 16-word frames back to back with s_valid held 1 -> two m0_valid pulses exactly 16 cycles apart and two res_valid pulses exactly 16 cycles apart.
REQ-034 The bench SHALL cover: rst asserted for one cycle after 7 words of a frame -> no m0_valid; next full 16-word frame emits with slots 0-15 from the new frame only.
REQ-035 The bench SHALL cover: 300 short frames with the macro defined -> short_cnt saturates at 255.

Source files
------------

// File: rtl/logicnet_input_packer.sv
// Packs a word stream into NWORDS-wide feature vectors for a LogicNet classifier.
// Optional per-error frame counters are enabled with LOGICNET_PACKER_ERRCNT_EN.
module logicnet_input_packer #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 16,
  parameter int LAT    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WORD_W-1:0]        s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [WORD_W*NWORDS-1:0] M0,
  output logic                     m0_valid,
  output logic                     res_valid,
`ifdef LOGICNET_PACKER_ERRCNT_EN
  output logic [7:0]               short_cnt,
  output logic [7:0]               long_cnt,
`endif
  output logic                     err_short,
  output logic                     err_long
);

  localparam int VEC_W = WORD_W * NWORDS;
  localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [VEC_W-1:0] r_buf;
  logic [VEC_W-1:0] r_m0;
  logic             r_m0_valid;
  logic [LAT-1:0]   r_res_sr;
  logic             r_err_short;
  logic             r_err_long;

  logic             w_acc;
  logic             w_fill;
  logic             w_last_slot;
  logic             w_emit;
  logic             w_short;
  logic             w_long;
  logic [VEC_W-1:0] w_merged;

  assign s_ready     = ~rst;
  assign w_acc       = s_valid & s_ready;
  assign w_fill      = (r_state == ST_FILL);
  assign w_last_slot = (r_cnt == CNT_W'(NWORDS - 1));
  assign w_emit      = w_acc & w_fill & (s_last | w_last_slot);
  assign w_short     = w_acc & w_fill & s_last & ~w_last_slot;
  assign w_long      = w_acc & w_fill & ~s_last & w_last_slot;

  // Slots above the current index are always zero because the buffer is cleared on every emission.
  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_slot
      assign w_merged[gi*WORD_W +: WORD_W] =
        (r_cnt == CNT_W'(gi)) ? s_data : r_buf[gi*WORD_W +: WORD_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FILL;
      r_cnt       <= '0;
      r_buf       <= '0;
      r_m0        <= '0;
      r_m0_valid  <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_m0_valid <= w_emit;
      if (w_emit) begin
        r_m0 <= w_merged;
      end
      if (w_acc && w_fill) begin
        if (w_emit) begin
          r_cnt <= '0;
          r_buf <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          r_buf <= w_merged;
        end
        if (w_long) begin
          r_state <= ST_DRAIN;
        end
      end
      if (w_acc && !w_fill && s_last) begin
        r_state <= ST_FILL;
        r_cnt   <= '0;
      end
      if (w_short) begin
        r_err_short <= 1'b1;
      end
      if (w_long) begin
        r_err_long <= 1'b1;
      end
    end
  end

  // Result-valid tracks each emission through the classifier pipeline depth.
  generate
    if (LAT == 1) begin : g_sr1
      always_ff @(posedge clk) begin
        if (rst) begin
          r_res_sr <= '0;
        end else begin
          r_res_sr <= r_m0_valid;
        end
      end
    end else begin : g_srn
      always_ff @(posedge clk) begin
        if (rst) begin
          r_res_sr <= '0;
        end else begin
          r_res_sr <= {r_res_sr[LAT-2:0], r_m0_valid};
        end
      end
    end
  endgenerate

`ifdef LOGICNET_PACKER_ERRCNT_EN
  logic [7:0] r_short_cnt;
  logic [7:0] r_long_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_short_cnt <= '0;
      r_long_cnt  <= '0;
    end else begin
      if (w_short && (r_short_cnt != 8'hFF)) begin
        r_short_cnt <= r_short_cnt + 8'd1;
      end
      if (w_long && (r_long_cnt != 8'hFF)) begin
        r_long_cnt <= r_long_cnt + 8'd1;
      end
    end
  end

  assign short_cnt = r_short_cnt;
  assign long_cnt  = r_long_cnt;
`endif

  assign M0        = r_m0;
  assign m0_valid  = r_m0_valid;
  assign res_valid = r_res_sr[LAT-1];
  assign err_short = r_err_short;
  assign err_long  = r_err_long;

endmodule

// File: tb/tb_logicnet_input_packer.sv
// Directed self-checking bench for logicnet_input_packer at default parameters.
// Counter checks run only when LOGICNET_PACKER_ERRCNT_EN is defined.
module tb_logicnet_input_packer;

  localparam int WORD_W = 32;
  localparam int NWORDS = 16;
  localparam int LAT    = 4;
  localparam int VEC_W  = WORD_W * NWORDS;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [WORD_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic [VEC_W-1:0]  M0;
  logic              m0_valid;
  logic              res_valid;
  logic              err_short;
  logic              err_long;
`ifdef LOGICNET_PACKER_ERRCNT_EN
  logic [7:0]        short_cnt;
  logic [7:0]        long_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int m0_cyc[$];
  int res_cyc[$];

  logic [VEC_W-1:0] exp_vec;

  logicnet_input_packer #(.WORD_W(WORD_W), .NWORDS(NWORDS), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .M0        (M0),
    .m0_valid  (m0_valid),
    .res_valid (res_valid),
`ifdef LOGICNET_PACKER_ERRCNT_EN
    .short_cnt (short_cnt),
    .long_cnt  (long_cnt),
`endif
    .err_short (err_short),
    .err_long  (err_long)
  );

  always #5 clk = ~clk;

  // Pulse log: each output sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (m0_valid === 1'b1) m0_cyc.push_back(cyc);
    if (res_valid === 1'b1) res_cyc.push_back(cyc);
  end

  task automatic send(input logic [WORD_W-1:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = 32'h1234_5678;
    @(posedge clk); #1;
    n_checks++;
    if (s_ready !== 1'b0) $display("FAIL reset_s_ready got %b want 0", s_ready); else n_pass++;
    n_checks++;
    if (M0 !== '0 || m0_valid !== 1'b0 || res_valid !== 1'b0)
      $display("FAIL reset_outputs got M0=%h m0v=%b resv=%b want 0", M0, m0_valid, res_valid);
    else n_pass++;
    n_checks++;
    if (err_short !== 1'b0 || err_long !== 1'b0)
      $display("FAIL reset_errs got %b%b want 00", err_short, err_long);
    else n_pass++;
    rst = 1'b0;
    s_valid = 1'b0;
    #1;
    n_checks++;
    if (s_ready !== 1'b1) $display("FAIL ready_after_reset got %b want 1", s_ready); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_full_frame();
    logic [VEC_W-1:0] held;
    do_reset();
    for (int i = 0; i < NWORDS; i++) send(WORD_W'(i), (i == NWORDS - 1));
    n_checks++;
    if (m0_valid !== 1'b1) $display("FAIL full_m0_valid got %b want 1", m0_valid); else n_pass++;
    n_checks++;
    if (M0[31:0] !== 32'h0 || M0[511:480] !== 32'hF)
      $display("FAIL full_slots got lo=%h hi=%h want 0 f", M0[31:0], M0[511:480]);
    else n_pass++;
    exp_vec = '0;
    for (int i = 0; i < NWORDS; i++) exp_vec[i*WORD_W +: WORD_W] = WORD_W'(i);
    n_checks++;
    if (M0 !== exp_vec) $display("FAIL full_vec got %h want %h", M0, exp_vec); else n_pass++;
    n_checks++;
    if (err_short !== 1'b0 || err_long !== 1'b0)
      $display("FAIL full_errs got %b%b want 00", err_short, err_long);
    else n_pass++;
    idle(1);
    n_checks++;
    if (m0_valid !== 1'b0) $display("FAIL full_m0_pulse_width got %b want 0", m0_valid); else n_pass++;
    idle(2);
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL full_res_early got %b want 0", res_valid); else n_pass++;
    idle(1);
    n_checks++;
    if (res_valid !== 1'b1) $display("FAIL full_res_lat got %b want 1", res_valid); else n_pass++;
    idle(1);
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL full_res_width got %b want 0", res_valid); else n_pass++;
    held = M0;
    for (int i = 0; i < 5; i++) send(32'hEEEE_0000 + WORD_W'(i), 1'b0);
    idle(1);
    n_checks++;
    if (M0 !== exp_vec) $display("FAIL m0_hold got %h want %h", M0, held); else n_pass++;
    $display("test_full_frame done");
  endtask

  task automatic test_short();
    do_reset();
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    send(32'hC, 1'b1);
    n_checks++;
    if (m0_valid !== 1'b1) $display("FAIL short_m0_valid got %b want 1", m0_valid); else n_pass++;
    n_checks++;
    if (M0[95:0] !== {32'hC, 32'hB, 32'hA} || M0[511:96] !== '0)
      $display("FAIL short_vec got %h want c/b/a zero-filled", M0);
    else n_pass++;
    n_checks++;
    if (err_short !== 1'b1 || err_long !== 1'b0)
      $display("FAIL short_errs got %b%b want 10", err_short, err_long);
    else n_pass++;
`ifdef LOGICNET_PACKER_ERRCNT_EN
    n_checks++;
    if (short_cnt !== 8'd1) $display("FAIL short_cnt got %0d want 1", short_cnt); else n_pass++;
`endif
    idle(3);
    n_checks++;
    if (err_short !== 1'b1) $display("FAIL short_sticky got %b want 1", err_short); else n_pass++;
    $display("test_short done");
  endtask

  task automatic test_long();
    do_reset();
    idle(1);
    m0_cyc.delete();
    for (int i = 0; i < 20; i++) begin
      send(32'h100 + WORD_W'(i), (i == 19));
      if (i == NWORDS - 1) begin
        n_checks++;
        if (m0_valid !== 1'b1 || M0[511:480] !== 32'h10F || M0[31:0] !== 32'h100)
          $display("FAIL long_emit got v=%b hi=%h lo=%h want 1 10f 100", m0_valid, M0[511:480], M0[31:0]);
        else n_pass++;
      end
    end
    idle(2);
    n_checks++;
    if (m0_cyc.size() != 1) $display("FAIL long_emissions got %0d want 1", m0_cyc.size()); else n_pass++;
    n_checks++;
    if (err_long !== 1'b1 || err_short !== 1'b0)
      $display("FAIL long_errs got s=%b l=%b want 0 1", err_short, err_long);
    else n_pass++;
    for (int i = 0; i < NWORDS; i++) send(32'h200 + WORD_W'(i), (i == NWORDS - 1));
    exp_vec = '0;
    for (int i = 0; i < NWORDS; i++) exp_vec[i*WORD_W +: WORD_W] = 32'h200 + WORD_W'(i);
    n_checks++;
    if (m0_valid !== 1'b1 || M0 !== exp_vec)
      $display("FAIL long_recover got v=%b M0=%h want 1 %h", m0_valid, M0, exp_vec);
    else n_pass++;
`ifdef LOGICNET_PACKER_ERRCNT_EN
    n_checks++;
    if (long_cnt !== 8'd1 || short_cnt !== 8'd0)
      $display("FAIL long_cnt got l=%0d s=%0d want 1 0", long_cnt, short_cnt);
    else n_pass++;
`endif
    idle(1);
    $display("test_long done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    idle(1);
    m0_cyc.delete();
    res_cyc.delete();
    for (int i = 0; i < 2 * NWORDS; i++) send(32'h500 + WORD_W'(i), ((i % NWORDS) == NWORDS - 1));
    idle(LAT + 3);
    n_checks++;
    if (m0_cyc.size() != 2 || res_cyc.size() != 2)
      $display("FAIL b2b_counts got m0=%0d res=%0d want 2 2", m0_cyc.size(), res_cyc.size());
    else n_pass++;
    if (m0_cyc.size() == 2 && res_cyc.size() == 2) begin
      n_checks++;
      if (m0_cyc[1] - m0_cyc[0] != NWORDS)
        $display("FAIL b2b_m0_gap got %0d want %0d", m0_cyc[1] - m0_cyc[0], NWORDS);
      else n_pass++;
      n_checks++;
      if (res_cyc[1] - res_cyc[0] != NWORDS)
        $display("FAIL b2b_res_gap got %0d want %0d", res_cyc[1] - res_cyc[0], NWORDS);
      else n_pass++;
      n_checks++;
      if (res_cyc[0] - m0_cyc[0] != LAT)
        $display("FAIL b2b_res_lat got %0d want %0d", res_cyc[0] - m0_cyc[0], LAT);
      else n_pass++;
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    idle(1);
    m0_cyc.delete();
    res_cyc.delete();
    for (int i = 0; i < 7; i++) send(32'h300 + WORD_W'(i), 1'b0);
    do_reset();
    idle(2);
    n_checks++;
    if (m0_cyc.size() != 0 || M0 !== '0)
      $display("FAIL midrst_no_emit got n=%0d M0=%h want 0", m0_cyc.size(), M0);
    else n_pass++;
    send(32'h777, 1'b1);
    do_reset();
    idle(LAT + 2);
    n_checks++;
    if (res_cyc.size() != 0) $display("FAIL midrst_res_flush got %0d want 0", res_cyc.size()); else n_pass++;
    for (int i = 0; i < NWORDS; i++) send(32'h400 + WORD_W'(i), (i == NWORDS - 1));
    exp_vec = '0;
    for (int i = 0; i < NWORDS; i++) exp_vec[i*WORD_W +: WORD_W] = 32'h400 + WORD_W'(i);
    n_checks++;
    if (m0_valid !== 1'b1 || M0 !== exp_vec)
      $display("FAIL midrst_next got v=%b M0=%h want 1 %h", m0_valid, M0, exp_vec);
    else n_pass++;
    idle(1);
    $display("test_reset_mid done");
  endtask

  task automatic test_single_word();
    send(32'hDEAD_BEEF, 1'b1);
    exp_vec = '0;
    exp_vec[31:0] = 32'hDEAD_BEEF;
    n_checks++;
    if (m0_valid !== 1'b1 || M0 !== exp_vec)
      $display("FAIL single_word got v=%b M0=%h want 1 %h", m0_valid, M0, exp_vec);
    else n_pass++;
    n_checks++;
    if (err_short !== 1'b1) $display("FAIL single_err_short got %b want 1", err_short); else n_pass++;
    idle(1);
    $display("test_single_word done");
  endtask

`ifdef LOGICNET_PACKER_ERRCNT_EN
  task automatic test_errcnt_sat();
    do_reset();
    for (int i = 0; i < 300; i++) send(WORD_W'(i), 1'b1);
    idle(1);
    n_checks++;
    if (short_cnt !== 8'd255 || long_cnt !== 8'd0)
      $display("FAIL cnt_saturate got s=%0d l=%0d want 255 0", short_cnt, long_cnt);
    else n_pass++;
    do_reset();
    n_checks++;
    if (short_cnt !== 8'd0) $display("FAIL cnt_reset got %0d want 0", short_cnt); else n_pass++;
    $display("test_errcnt_sat done");
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_full_frame();
    test_short();
    test_long();
    test_back_to_back();
    test_reset_mid();
    test_single_word();
`ifdef LOGICNET_PACKER_ERRCNT_EN
    test_errcnt_sat();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
